rom_stream_reader: RTL and testbench
====================================

// Module: rom_stream_reader
// PURPOSE
//  Read-side initiator for the 4Kx8 ROM: drives the ROM address, captures the read data and streams bytes out.
//  A start pulse gives a base address and byte count. The block fetches len consecutive bytes.
//  Bytes leave on a valid/ready port, so downstream logic reads ROM contents without its own address sequencing.
// PARAMETERS
//  AW      12  ROM address width (4096 words)
//  DW      8   ROM data width
//  RD_LAT  0   ROM read latency in cycles; 0 = combinational ROM, 1 = registered ROM output
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin transfer; sampled only in IDLE
//  start_addr  in   AW     first address
//  len         in   AW+1   byte count, 0..4096
//  rom_addr    out  AW     address to ROM
//  rom_data    in   DW     ROM read data
//  out_data    out  DW     fetched byte
//  out_valid   out  1      out_data valid
//  out_ready   in   1      consumer accepts byte
//  busy        out  1      high in every state except IDLE
//  done        out  1      one-cycle pulse at end of transfer
//  checksum    out  DW     only with CHECKSUM_EN
// BEHAVIOUR
//  Reset values: rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0; state=IDLE.
//  Reset wins over all other inputs in the same cycle. Reset mid-transfer aborts with no done pulse.
//  FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
//   IDLE:    on start, load rom_addr<=start_addr and remaining<=len.
//            Go to DONE if len==0, else FETCH. start in any other state is ignored.
//   FETCH:   rom_addr stable. With RD_LAT=0, latch out_data<=rom_data and set out_valid; go to PRESENT.
//            With RD_LAT=1, go to WAIT.
//   WAIT:    (RD_LAT=1 only) latch out_data<=rom_data and set out_valid; go to PRESENT.
//   PRESENT: hold out_data and out_valid stable until out_ready. On handshake: clear out_valid and decrement remaining.
//            If remaining was 1, go to DONE. Otherwise rom_addr<=rom_addr+1 and go to FETCH.
//   DONE:    done=1 for exactly one cycle; go to IDLE.
//  Latency: start edge -> first out_valid after 2 cycles (RD_LAT=0) or 3 cycles (RD_LAT=1).
//  Throughput: one byte per 2 (RD_LAT=0) or 3 (RD_LAT=1) cycles when out_ready is held high.
//  Address arithmetic is mod 2^AW, so 12'hFFF+1 wraps to 12'h000. A len=4096 transfer visits every address once.
//  rom_addr never changes while out_valid=1. out_data never changes while out_valid=1 and out_ready=0.
//  out_ready is ignored when out_valid=0.
// CONFIGURATION
//  Optional feature macro: ROM_READER_CHECKSUM_EN.
//  Defined: port checksum exists. It is cleared to 0 on an accepted start.
//   Each handshake adds out_data mod 2^DW. The value is final when done pulses and holds until the next start.
//  Undefined: no checksum port and no adder logic; all other behaviour is identical.
// STRUCTURE
//  Shared include rom_rd_defs.vh: state encodings (ST_IDLE..ST_DONE, 3-bit) and the AW/DW defaults.
//   The ROM and its testbench also use this file.
//  One sub-module, rom_addr_counter: loadable AW-bit wrapping address register plus AW+1-bit remaining down-counter.
//   Inputs are load/step; outputs are addr and last (remaining==1).
//  Top level holds the FSM, the output data register and the optional checksum.
// TESTING (bench ROM model: rom_data = addr[7:0] ^ 8'h5A, with RD_LAT matched to the DUT)
//  1. start_addr=0, len=4, out_ready=1
//     -> out_data sequence 5A,5B,58,59; first out_valid 2 cycles after start (RD_LAT=0).
//     -> done pulses once after the 4th handshake; busy=0 the following cycle.
//  2. start_addr=12'hFFE, len=4
//     -> rom_addr sequence FFE,FFF,000,001; out_data A4,A5,5A,5B.
//  3. len=0 -> done high exactly one cycle; out_valid never asserts; rom_addr=start_addr.
//  4. len=3, out_ready low for 5 cycles while byte 2 is valid
//     -> out_data=5B and rom_addr=001 stay stable; a start pulse during the stall is ignored.
//     -> after ready, the remaining bytes follow in order.
//  5. reset asserted after 2 handshakes of a len=8 transfer
//     -> next cycle busy=0, out_valid=0, rom_addr=0, no done pulse.
//     -> a following start_addr=10, len=1 yields out_data=8'h50.
//  6. ROM_READER_CHECKSUM_EN defined, repeat scenario 1 -> checksum=8'h66 at the done pulse, held afterwards.
//  7. Repeat scenarios 1-5 with RD_LAT=1 -> same data; first out_valid 3 cycles after start.

Source files
------------

// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader: default geometry and FSM state encodings.
// The encodings are also visible to anything that decodes the reader's debug state.
package rom_stream_reader_pkg;

  localparam int ROM_AW = 12;
  localparam int ROM_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A combinational ROM can be captured straight out of FETCH; a registered one needs WAIT.
  function automatic state_t after_fetch(input int rd_lat);
    return (rd_lat == 0) ? ST_PRESENT : ST_WAIT;
  endfunction

endpackage

// File: rtl/rom_addr_counter.sv
// Loadable wrapping address register plus remaining-byte down-counter for the ROM reader.
// o_last flags the final byte so the address is not advanced past it.
module rom_addr_counter #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_addr,
  input  logic [AW:0]   i_len,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);

  logic [AW-1:0] r_addr;
  logic [AW:0]   r_remaining;
  logic          w_last;

  assign w_last = (r_remaining == LEN_ONE);

  // Address arithmetic is naturally mod 2^AW through the register width.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_remaining <= r_remaining - LEN_ONE;
      if (!w_last) begin
        r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_last;

endmodule

// File: rtl/rom_stream_reader.sv
// Read-side initiator for the ROM: fetches len bytes from start_addr and streams them out.
// Build option ROM_READER_CHECKSUM_EN adds a running mod-2^DW checksum of accepted bytes.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int AW     = ROM_AW,
  parameter int DW     = ROM_DW,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
`ifdef ROM_READER_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  output logic [2:0]    dbg_state
);

  // Output handshake: a byte transfers on a rising edge where out_valid and out_ready are
  // both high; out_valid never drops and out_data never changes before that edge, and
  // out_ready has no effect while out_valid is low.

  state_t        r_state;
  state_t        w_next_state;
  logic          w_load;
  logic          w_step;
  logic          w_capture;
  logic          w_last;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;

  rom_addr_counter #(
    .AW(AW)
  ) u_addr_counter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_addr  (start_addr),
    .i_len   (len),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = (len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_capture    = (RD_LAT == 0);
        w_next_state = after_fetch(RD_LAT);
      end
      ST_WAIT: begin
        w_capture    = 1'b1;
        w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          w_step       = 1'b1;
          w_next_state = w_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= rom_data;
      r_out_valid <= 1'b1;
    end else if (w_step) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  // Holds its final value after done until the next accepted start clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if (w_step) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign rom_addr  = w_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: one reader with a combinational ROM and one with a registered ROM,
// both fed from a model ROM (data = addr[7:0] ^ 8'h5A) and checked through a byte scoreboard.
module tb_rom_stream_reader;
  import rom_stream_reader_pkg::*;

  logic        clk = 1'b0;
  logic [1:0]  reset;
  logic [1:0]  start;
  logic [1:0]  out_ready;
  logic [1:0]  out_valid;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [11:0] start_addr;
  logic [12:0] len;
  logic [11:0] rom_addr [2];
  logic [7:0]  out_data [2];
  logic [2:0]  dbg_state [2];
  logic [7:0]  rom_data0;
  logic [7:0]  rom_data1;
`ifdef ROM_READER_CHECKSUM_EN
  logic [7:0]  checksum [2];
`endif

  logic [7:0]  exp_q[$];
  logic [11:0] exp_a[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign rom_data0 = rom_model(rom_addr[0]);
  always @(posedge clk) rom_data1 <= rom_model(rom_addr[1]);

  rom_stream_reader #(.AW(12), .DW(8), .RD_LAT(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset[0]),
    .start      (start[0]),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr[0]),
    .rom_data   (rom_data0),
    .out_data   (out_data[0]),
    .out_valid  (out_valid[0]),
    .out_ready  (out_ready[0]),
    .busy       (busy[0]),
    .done       (done[0]),
`ifdef ROM_READER_CHECKSUM_EN
    .checksum   (checksum[0]),
`endif
    .dbg_state  (dbg_state[0])
  );

  rom_stream_reader #(.AW(12), .DW(8), .RD_LAT(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset[1]),
    .start      (start[1]),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr[1]),
    .rom_data   (rom_data1),
    .out_data   (out_data[1]),
    .out_valid  (out_valid[1]),
    .out_ready  (out_ready[1]),
    .busy       (busy[1]),
    .done       (done[1]),
`ifdef ROM_READER_CHECKSUM_EN
    .checksum   (checksum[1]),
`endif
    .dbg_state  (dbg_state[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
  endtask

  task automatic fail_now(input string name, input int d);
    n_checks++;
    $display("FAIL %s dut%0d: got event expected none", name, d);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-stability while stalled.
  task automatic monitor();
    logic [1:0]  pv;
    logic [1:0]  pr;
    logic [7:0]  pd [2];
    logic [11:0] pa [2];
    logic [7:0]  e;
    logic [11:0] ea;
    pv = '0;
    pr = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && pv[d] && !pr[d]) begin
          chk("addr_stable", d, 32'(rom_addr[d]), 32'(pa[d]));
          chk("data_stable", d, 32'(out_data[d]), 32'(pd[d]));
        end
        if (out_valid[d] && out_ready[d]) begin
          if (exp_q.size() == 0 || exp_a.size() == 0) begin
            fail_now("unexpected_byte", d);
          end else begin
            e  = exp_q.pop_front();
            ea = exp_a.pop_front();
            chk("byte_data", d, 32'(out_data[d]), 32'(e));
            chk("byte_addr", d, 32'(rom_addr[d]), 32'(ea));
          end
        end
        pv[d] = out_valid[d];
        pr[d] = out_ready[d];
        pd[d] = out_data[d];
        pa[d] = rom_addr[d];
      end
    end
  endtask

  // mode 0: ready held high; 1: random ready; 2: 5-cycle stall on byte 2 with an ignored start;
  // 3: reset after the second handshake.
  task automatic run_xfer(input int d, input logic [11:0] sa, input logic [12:0] ln, input int mode);
    int          cyc;
    int          hs;
    int          stall;
    int          first_v;
    int          budget;
    bit          seen_done;
    bit          finished;
    bit          aborted;
    bit          reset_sent;
    logic [11:0] a1;
    logic [11:0] end_addr;
`ifdef ROM_READER_CHECKSUM_EN
    logic [7:0]  sum;
    sum = 8'h00;
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(ln); i++) begin
      exp_a.push_back(sa + 12'(i));
      exp_q.push_back(rom_model(sa + 12'(i)));
`ifdef ROM_READER_CHECKSUM_EN
      sum = sum + rom_model(sa + 12'(i));
`endif
    end
    a1         = sa + 12'd1;
    end_addr   = (ln == 13'd0) ? sa : sa + 12'(ln - 13'd1);
    start_addr = sa;
    len        = ln;
    start[d]   = 1'b1;
    out_ready[d] = 1'b1;
    cyc = 0; hs = 0; stall = 5; first_v = -1; budget = int'(ln) * 40 + 40;
    seen_done = 0; finished = 0; aborted = 0; reset_sent = 0;
    while (!finished && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start[d] = 1'b0;
      if (reset[d]) begin
        reset[d] = 1'b0;
        chk("abort_busy", d, 32'(busy[d]), 32'd0);
        chk("abort_valid", d, 32'(out_valid[d]), 32'd0);
        chk("abort_addr", d, 32'(rom_addr[d]), 32'd0);
        chk("abort_done", d, 32'(done[d]), 32'd0);
        chk("abort_state", d, 32'(dbg_state[d]), 32'(ST_IDLE));
`ifdef ROM_READER_CHECKSUM_EN
        chk("abort_checksum", d, 32'(checksum[d]), 32'd0);
`endif
        chk("abort_no_done", d, 32'(seen_done), 32'd0);
        aborted  = 1;
        finished = 1;
      end else if (seen_done) begin
        chk("done_one_cycle", d, 32'(done[d]), 32'd0);
        chk("busy_after_done", d, 32'(busy[d]), 32'd0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("checksum_held", d, 32'(checksum[d]), 32'(sum));
`endif
        finished = 1;
      end else begin
        if (out_valid[d] && first_v < 0) first_v = cyc;
        if (done[d]) begin
          seen_done = 1;
`ifdef ROM_READER_CHECKSUM_EN
          chk("checksum_at_done", d, 32'(checksum[d]), 32'(sum));
`endif
        end
        case (mode)
          1: out_ready[d] = ($urandom_range(0, 3) != 0);
          2: begin
            if (out_valid[d] && hs == 1 && stall > 0) begin
              out_ready[d] = 1'b0;
              if (stall == 3) begin
                start[d]   = 1'b1;
                start_addr = 12'h300;
                len        = 13'd1;
              end else begin
                start[d] = 1'b0;
              end
              stall--;
              if (stall == 0) begin
                chk("stall_data", d, 32'(out_data[d]), 32'(rom_model(a1)));
                chk("stall_addr", d, 32'(rom_addr[d]), 32'(a1));
              end
            end else begin
              out_ready[d] = 1'b1;
              start[d]     = 1'b0;
            end
          end
          3: begin
            out_ready[d] = 1'b1;
            if (hs == 2 && !reset_sent) begin
              reset[d]   = 1'b1;
              reset_sent = 1;
            end
          end
          default: out_ready[d] = 1'b1;
        endcase
        if (out_valid[d] && out_ready[d]) hs++;
      end
    end
    start[d] = 1'b0;
    if (!finished) begin
      fail_now("timeout", d);
      reset[d] = 1'b1;
      @(posedge clk);
      #1;
      reset[d] = 1'b0;
      exp_q.delete();
      exp_a.delete();
    end else if (aborted) begin
      exp_q.delete();
      exp_a.delete();
    end else begin
      chk("first_valid_latency", d, 32'(first_v), (ln == 13'd0) ? 32'hFFFF_FFFF : 32'(2 + d));
      chk("bytes_left", d, 32'(exp_q.size()), 32'd0);
      chk("end_addr", d, 32'(rom_addr[d]), 32'(end_addr));
    end
  endtask

  initial begin
    reset      = '1;
    start      = '0;
    out_ready  = '0;
    start_addr = '0;
    len        = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = '0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_addr", d, 32'(rom_addr[d]), 32'd0);
      chk("reset_data", d, 32'(out_data[d]), 32'd0);
      chk("reset_valid", d, 32'(out_valid[d]), 32'd0);
      chk("reset_busy", d, 32'(busy[d]), 32'd0);
      chk("reset_done", d, 32'(done[d]), 32'd0);
      chk("reset_state", d, 32'(dbg_state[d]), 32'(ST_IDLE));
`ifdef ROM_READER_CHECKSUM_EN
      chk("reset_checksum", d, 32'(checksum[d]), 32'd0);
`endif
    end
    for (int d = 0; d < 2; d++) begin
      run_xfer(d, 12'h000, 13'd4, 0);
      run_xfer(d, 12'hFFE, 13'd4, 0);
      run_xfer(d, 12'h123, 13'd0, 0);
      run_xfer(d, 12'h000, 13'd3, 2);
      run_xfer(d, 12'h000, 13'd8, 3);
      run_xfer(d, 12'd10,  13'd1, 0);
      repeat (6) run_xfer(d, 12'($urandom_range(0, 4095)), 13'($urandom_range(1, 24)), 1);
      run_xfer(d, 12'($urandom_range(0, 4095)), 13'd4096, 0);
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
